// File: rtl/nf10_axis_pkg.sv
// Shared definitions for the NetFPGA-10G AXI4-Stream input arbiter slice:
// arbiter state encodings, tuser sideband field offsets and a constant log2.
package nf10_axis_pkg;

    // Arbiter states: waiting for a packet, or streaming one out
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WR_PKT = 1'b1
    } arb_state_t;

    // NetFPGA-10G tuser layout: [15:0] length, [23:16] src port, [31:24] dst port
    localparam int LEN_LSB      = 0;
    localparam int SRC_PORT_LSB = 16;
    localparam int DST_PORT_LSB = 24;

    // Ceiling log2, meant for elaboration-time sizing of index fields
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the oldest entry is always presented on
// dout, so a beat written at one edge is readable in the very next cycle.
// nearly_full is raised with one free slot left so that a producer that
// decides to write one cycle ahead can never overflow it.
module fallthrough_small_fifo
    import nf10_axis_pkg::*;
#(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             axi_aclk,
    input  logic             axi_reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int MAX_DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] FULL_LEVEL        = (MAX_DEPTH_BITS + 1)'(MAX_DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NEARLY_FULL_LEVEL = (MAX_DEPTH_BITS + 1)'(MAX_DEPTH - 1);

    logic [WIDTH-1:0]          mem [MAX_DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      wr_fire;
    logic                      rd_fire;

    assign wr_fire     = wr_en && (depth != FULL_LEVEL);
    assign rd_fire     = rd_en && !empty;
    assign empty       = (depth == '0);
    assign nearly_full = (depth >= NEARLY_FULL_LEVEL);
    assign dout        = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset flushes all stored beats
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + (MAX_DEPTH_BITS)'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + (MAX_DEPTH_BITS)'(1);
            end
            unique case ({wr_fire, rd_fire})
                2'b10:   depth <= depth + (MAX_DEPTH_BITS + 1)'(1);
                2'b01:   depth <= depth - (MAX_DEPTH_BITS + 1)'(1);
                default: depth <= depth;
            endcase
        end
    end

    // Storage array is data only, so it needs no reset
    always_ff @(posedge axi_aclk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/nf10_input_arbiter_rr.sv
// Packet-level round-robin arbiter merging five AXI4-Stream ingress ports into
// one master stream. Each input lands in a small fall-through FIFO; whole
// packets are forwarded atomically, and tuser is passed through untouched.
module nf10_input_arbiter_rr
    import nf10_axis_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH = 256,
    parameter int C_USER_WIDTH      = 128,
    parameter int NUM_QUEUES        = 5,
    parameter int FIFO_DEPTH_BITS   = 2
) (
    input  logic                           axi_aclk,
    input  logic                           axi_reset,

    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_0,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_0,
    input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_0,
    input  logic                           s_axis_tvalid_0,
    output logic                           s_axis_tready_0,
    input  logic                           s_axis_tlast_0,

    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_1,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_1,
    input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_1,
    input  logic                           s_axis_tvalid_1,
    output logic                           s_axis_tready_1,
    input  logic                           s_axis_tlast_1,

    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_2,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_2,
    input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_2,
    input  logic                           s_axis_tvalid_2,
    output logic                           s_axis_tready_2,
    input  logic                           s_axis_tlast_2,

    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_3,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_3,
    input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_3,
    input  logic                           s_axis_tvalid_3,
    output logic                           s_axis_tready_3,
    input  logic                           s_axis_tlast_3,

    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_4,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_4,
    input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_4,
    input  logic                           s_axis_tvalid_4,
    output logic                           s_axis_tready_4,
    input  logic                           s_axis_tlast_4,

    output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [C_USER_WIDTH-1:0]        m_axis_tuser,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast
);

    localparam int STRB_WIDTH = C_AXIS_DATA_WIDTH / 8;
    localparam int FIFO_WIDTH = C_AXIS_DATA_WIDTH + C_USER_WIDTH + STRB_WIDTH + 1;
    localparam int QIDX_W     = log2(NUM_QUEUES);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [QIDX_W-1:0] cur_queue;
    logic [QIDX_W-1:0] cur_queue_next;
    logic [QIDX_W-1:0] last_grant;
    logic [QIDX_W-1:0] last_grant_next;

    logic [FIFO_WIDTH-1:0] fifo_din  [NUM_QUEUES];
    logic [FIFO_WIDTH-1:0] fifo_dout [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] fifo_wr_en;
    logic [NUM_QUEUES-1:0] fifo_rd_en;
    logic [NUM_QUEUES-1:0] fifo_nearly_full;
    logic [NUM_QUEUES-1:0] fifo_empty;
    logic [NUM_QUEUES-1:0] in_valid;
    logic [NUM_QUEUES-1:0] in_ready;

    logic                          head_last;
    logic [C_USER_WIDTH-1:0]       head_user;
    logic [STRB_WIDTH-1:0]         head_strb;
    logic [C_AXIS_DATA_WIDTH-1:0]  head_data;
    logic                          head_avail;

    logic                          grant_found;
    logic [QIDX_W-1:0]             grant_idx;

    // Round-robin search: first non-empty queue after the last one served,
    // wrapping 4 -> 0. The MSB of the result flags whether anything was found.
    function automatic logic [QIDX_W:0] rr_pick(input logic [QIDX_W-1:0] last,
                                                input logic [NUM_QUEUES-1:0] empty_vec);
        logic [QIDX_W:0]   result;
        logic [QIDX_W-1:0] idx_l;
        int                idx;
        result = '0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            idx = int'(last) + k;
            if (idx >= NUM_QUEUES) begin
                idx = idx - NUM_QUEUES;
            end
            idx_l = idx[QIDX_W-1:0];
            if (!result[QIDX_W] && !empty_vec[idx_l]) begin
                result = {1'b1, idx_l};
            end
        end
        return result;
    endfunction

    // Gather the per-port ingress signals into indexable vectors
    assign fifo_din[0] = {s_axis_tlast_0, s_axis_tuser_0, s_axis_tstrb_0, s_axis_tdata_0};
    assign fifo_din[1] = {s_axis_tlast_1, s_axis_tuser_1, s_axis_tstrb_1, s_axis_tdata_1};
    assign fifo_din[2] = {s_axis_tlast_2, s_axis_tuser_2, s_axis_tstrb_2, s_axis_tdata_2};
    assign fifo_din[3] = {s_axis_tlast_3, s_axis_tuser_3, s_axis_tstrb_3, s_axis_tdata_3};
    assign fifo_din[4] = {s_axis_tlast_4, s_axis_tuser_4, s_axis_tstrb_4, s_axis_tdata_4};

    assign in_valid = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2,
                       s_axis_tvalid_1, s_axis_tvalid_0};

    // Ready is held low through reset so no beat is taken into a flushing FIFO
    assign in_ready   = ~fifo_nearly_full & {NUM_QUEUES{~axi_reset}};
    assign fifo_wr_en = in_valid & in_ready;

    assign s_axis_tready_0 = in_ready[0];
    assign s_axis_tready_1 = in_ready[1];
    assign s_axis_tready_2 = in_ready[2];
    assign s_axis_tready_3 = in_ready[3];
    assign s_axis_tready_4 = in_ready[4];

    generate
        for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_in_fifo
            fallthrough_small_fifo #(
                .WIDTH          (FIFO_WIDTH),
                .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
            ) u_in_fifo (
                .axi_aclk    (axi_aclk),
                .axi_reset   (axi_reset),
                .din         (fifo_din[i]),
                .wr_en       (fifo_wr_en[i]),
                .rd_en       (fifo_rd_en[i]),
                .dout        (fifo_dout[i]),
                .nearly_full (fifo_nearly_full[i]),
                .empty       (fifo_empty[i])
            );
        end
    endgenerate

    // Egress fields come straight from the granted FIFO head and registered
    // state, so nothing here depends combinationally on m_axis_tready
    assign {head_last, head_user, head_strb, head_data} = fifo_dout[cur_queue];
    assign head_avail   = ~fifo_empty[cur_queue];
    assign m_axis_tdata = head_data;
    assign m_axis_tstrb = head_strb;
    assign m_axis_tuser = head_user;
    assign m_axis_tlast = head_last;

    assign {grant_found, grant_idx} = rr_pick(last_grant, fifo_empty);

    // Arbiter registers; reset points last_grant at 4 so input 0 wins first
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state      <= IDLE;
            cur_queue  <= '0;
            last_grant <= QIDX_W'(NUM_QUEUES - 1);
        end else begin
            state      <= state_next;
            cur_queue  <= cur_queue_next;
            last_grant <= last_grant_next;
        end
    end

    // Grant in IDLE, then stream the granted queue until its tlast beat leaves;
    // an empty queue mid-packet just stalls, the grant is never dropped early
    always_comb begin
        state_next      = state;
        cur_queue_next  = cur_queue;
        last_grant_next = last_grant;
        fifo_rd_en      = '0;
        m_axis_tvalid   = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_found) begin
                    cur_queue_next = grant_idx;
                    state_next     = WR_PKT;
                end
            end
            WR_PKT: begin
                m_axis_tvalid         = head_avail;
                fifo_rd_en[cur_queue] = m_axis_tready && head_avail;
                if (m_axis_tready && head_avail && head_last) begin
                    last_grant_next = cur_queue;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nf10_input_arbiter_rr.sv
// Scoreboard bench for the five-input round-robin packet arbiter. Expected
// beats are queued in predicted egress order when stimulus is issued and are
// popped and compared as beats leave the master port.
module tb_nf10_input_arbiter_rr;

    typedef struct packed {
        logic [255:0] data;
        logic [127:0] user;
        logic [31:0]  strb;
        logic         last;
    } beat_t;

    logic         axi_aclk;
    logic         axi_reset;
    logic [255:0] s_tdata  [5];
    logic [31:0]  s_tstrb  [5];
    logic [127:0] s_tuser  [5];
    logic         s_tvalid [5];
    logic         s_tready [5];
    logic         s_tlast  [5];
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;

    int    checks;
    int    failures;
    int    cycle;
    int    acc [5];
    int    model_last;
    beat_t exp_q [$];
    int    xfer_cycles [$];
    beat_t mon_beat;
    logic         hold_pending;
    logic [255:0] held_data;
    logic         held_last;

    nf10_input_arbiter_rr dut (
        .axi_aclk        (axi_aclk),
        .axi_reset       (axi_reset),
        .s_axis_tdata_0  (s_tdata[0]),  .s_axis_tstrb_0 (s_tstrb[0]), .s_axis_tuser_0 (s_tuser[0]),
        .s_axis_tvalid_0 (s_tvalid[0]), .s_axis_tready_0(s_tready[0]), .s_axis_tlast_0 (s_tlast[0]),
        .s_axis_tdata_1  (s_tdata[1]),  .s_axis_tstrb_1 (s_tstrb[1]), .s_axis_tuser_1 (s_tuser[1]),
        .s_axis_tvalid_1 (s_tvalid[1]), .s_axis_tready_1(s_tready[1]), .s_axis_tlast_1 (s_tlast[1]),
        .s_axis_tdata_2  (s_tdata[2]),  .s_axis_tstrb_2 (s_tstrb[2]), .s_axis_tuser_2 (s_tuser[2]),
        .s_axis_tvalid_2 (s_tvalid[2]), .s_axis_tready_2(s_tready[2]), .s_axis_tlast_2 (s_tlast[2]),
        .s_axis_tdata_3  (s_tdata[3]),  .s_axis_tstrb_3 (s_tstrb[3]), .s_axis_tuser_3 (s_tuser[3]),
        .s_axis_tvalid_3 (s_tvalid[3]), .s_axis_tready_3(s_tready[3]), .s_axis_tlast_3 (s_tlast[3]),
        .s_axis_tdata_4  (s_tdata[4]),  .s_axis_tstrb_4 (s_tstrb[4]), .s_axis_tuser_4 (s_tuser[4]),
        .s_axis_tvalid_4 (s_tvalid[4]), .s_axis_tready_4(s_tready[4]), .s_axis_tlast_4 (s_tlast[4]),
        .m_axis_tdata    (m_tdata),
        .m_axis_tstrb    (m_tstrb),
        .m_axis_tuser    (m_tuser),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .m_axis_tlast    (m_tlast)
    );

    // 100 MHz clock
    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    // Free-running cycle count for latency and gap measurements
    always @(posedge axi_aclk) begin
        cycle <= cycle + 1;
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] mkUser(input int q, input int nbeats);
        logic [127:0] u;
        u          = '0;
        u[15:0]    = 16'(nbeats * 32);
        u[23:16]   = 8'(q);
        u[127:96]  = 32'hC0DE_0000 | 32'(q);
        return u;
    endfunction

    function automatic logic [31:0] mkStrb(input logic last);
        return last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [255:0] mkBase(input int q, input int pkt);
        return (256'(q) << 248) | (256'(pkt) << 8) | (256'(q) << 128);
    endfunction

    // Queue the expected beats of one packet and note its source as last served
    task automatic pushExp(input int q, input logic [255:0] base, input int nbeats);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = base + 256'(i);
            b.user = mkUser(q, nbeats);
            b.last = (i == nbeats - 1);
            b.strb = mkStrb(b.last);
            exp_q.push_back(b);
        end
        model_last = q;
    endtask

    // Drive one packet on input q, honouring tready, one beat per accept
    task automatic applyStimulus(input int q, input logic [255:0] base, input int nbeats);
        int guard;
        for (int i = 0; i < nbeats; i++) begin
            s_tdata[q]  = base + 256'(i);
            s_tuser[q]  = mkUser(q, nbeats);
            s_tlast[q]  = (i == nbeats - 1);
            s_tstrb[q]  = mkStrb(i == nbeats - 1);
            s_tvalid[q] = 1'b1;
            guard = 0;
            while (1) begin
                @(negedge axi_aclk);
                if (s_tready[q]) break;
                guard++;
                if (guard > 500) begin
                    checkOutput("drv_timeout", 256'(q), 256'hFF);
                    s_tvalid[q] = 1'b0;
                    return;
                end
            end
            @(posedge axi_aclk);
            #1;
        end
        s_tvalid[q] = 1'b0;
        s_tlast[q]  = 1'b0;
    endtask

    task automatic runTwoPackets(input int q);
        applyStimulus(q, mkBase(q, 0), 2);
        applyStimulus(q, mkBase(q, 1), 2);
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(negedge axi_aclk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", 256'(exp_q.size()), 256'(0));
        end
        repeat (3) @(posedge axi_aclk);
        #1;
    endtask

    // Count accepted ingress beats per input
    always @(negedge axi_aclk) begin
        for (int i = 0; i < 5; i++) begin
            if (!axi_reset && s_tvalid[i] && s_tready[i]) begin
                acc[i] = acc[i] + 1;
            end
        end
    end

    // Egress monitor: scoreboard compare on transfers, stability while stalled
    always @(negedge axi_aclk) begin
        if (axi_reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checkOutput("hold_tvalid", 256'(m_tvalid), 256'(1));
                checkOutput("hold_tdata", m_tdata, held_data);
                checkOutput("hold_tlast", 256'(m_tlast), 256'(held_last));
            end
            if (m_tvalid && m_tready) begin
                xfer_cycles.push_back(cycle);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", m_tdata, 256'(0));
                end else begin
                    mon_beat = exp_q.pop_front();
                    checkOutput("tdata", m_tdata, mon_beat.data);
                    checkOutput("tuser", 256'(m_tuser), 256'(mon_beat.user));
                    checkOutput("tstrb", 256'(m_tstrb), 256'(mon_beat.strb));
                    checkOutput("tlast", 256'(m_tlast), 256'(mon_beat.last));
                end
            end
            hold_pending = m_tvalid && !m_tready;
            held_data    = m_tdata;
            held_last    = m_tlast;
        end
    end

    initial begin
        int c0;
        int c1;
        int a0;
        int g;
        checks       = 0;
        failures     = 0;
        cycle        = 0;
        hold_pending = 1'b0;
        held_data    = '0;
        held_last    = 1'b0;
        model_last   = 4;
        for (int i = 0; i < 5; i++) begin
            acc[i]      = 0;
            s_tdata[i]  = '0;
            s_tstrb[i]  = '0;
            s_tuser[i]  = '0;
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
        end
        m_tready  = 1'b1;
        axi_reset = 1'b1;

        // Reset state
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        checkOutput("rst_tvalid", 256'(m_tvalid), 256'(0));
        for (int i = 0; i < 5; i++) begin
            checkOutput("rst_s_tready", 256'(s_tready[i]), 256'(0));
        end
        @(posedge axi_aclk);
        #1;
        axi_reset = 1'b0;
        @(negedge axi_aclk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("post_rst_s_tready", 256'(s_tready[i]), 256'(1));
        end
        @(posedge axi_aclk);
        #1;

        // Single 3-beat packet on input 2 and its first-beat latency
        $display("[TB] single input packet");
        pushExp(2, 256'hA1, 3);
        c0 = -100;
        c1 = 0;
        fork
            applyStimulus(2, 256'hA1, 3);
            begin
                g = 0;
                do begin
                    @(negedge axi_aclk);
                    g++;
                end while (!(s_tvalid[2] && s_tready[2]) && g < 50);
                c0 = cycle;
                g = 0;
                while (!m_tvalid && g < 50) begin
                    @(negedge axi_aclk);
                    g++;
                end
                c1 = cycle;
            end
        join
        checkOutput("latency", 256'(c1 - c0), 256'(2));
        waitDrain();

        // Fairness: two 2-beat packets on every input at once
        $display("[TB] fairness");
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 5; k++) begin
                pushExp((model_last + 1) % 5, mkBase((model_last + 1) % 5, r), 2);
            end
        end
        fork
            runTwoPackets(0);
            runTwoPackets(1);
            runTwoPackets(2);
            runTwoPackets(3);
            runTwoPackets(4);
        join
        waitDrain();

        // Backpressure on a 6-beat packet from input 1
        $display("[TB] backpressure");
        m_tready = 1'b0;
        a0 = acc[1];
        pushExp(1, mkBase(1, 5), 6);
        fork
            applyStimulus(1, mkBase(1, 5), 6);
            begin
                repeat (10) @(negedge axi_aclk);
                checkOutput("bp_accepted", 256'(acc[1] - a0), 256'(3));
                checkOutput("bp_s_tready1", 256'(s_tready[1]), 256'(0));
                checkOutput("bp_tvalid", 256'(m_tvalid), 256'(1));
                @(posedge axi_aclk);
                #1;
                m_tready = 1'b1;
            end
        join
        waitDrain();

        // Single-beat packets on inputs 3 and 4, one idle cycle apart
        $display("[TB] single-beat packets");
        xfer_cycles.delete();
        pushExp(3, mkBase(3, 7), 1);
        pushExp(4, mkBase(4, 7), 1);
        fork
            applyStimulus(3, mkBase(3, 7), 1);
            applyStimulus(4, mkBase(4, 7), 1);
        join
        waitDrain();
        checkOutput("sb_xfer_count", 256'(xfer_cycles.size()), 256'(2));
        if (xfer_cycles.size() == 2) begin
            checkOutput("sb_gap", 256'(xfer_cycles[1] - xfer_cycles[0]), 256'(2));
        end

        // Reset in the middle of a stalled packet from input 0
        $display("[TB] reset mid-packet");
        m_tready    = 1'b0;
        s_tdata[0]  = mkBase(0, 9);
        s_tuser[0]  = mkUser(0, 4);
        s_tstrb[0]  = mkStrb(1'b0);
        s_tlast[0]  = 1'b0;
        s_tvalid[0] = 1'b1;
        @(posedge axi_aclk);
        #1;
        s_tdata[0]  = mkBase(0, 9) + 256'(1);
        @(posedge axi_aclk);
        #1;
        s_tvalid[0] = 1'b0;
        @(negedge axi_aclk);
        checkOutput("pre_rst_tvalid", 256'(m_tvalid), 256'(1));
        #2;
        axi_reset  = 1'b1;
        model_last = 4;
        #1;
        checkOutput("midrst_tvalid", 256'(m_tvalid), 256'(0));
        for (int i = 0; i < 5; i++) begin
            checkOutput("midrst_s_tready", 256'(s_tready[i]), 256'(0));
        end
        repeat (2) @(posedge axi_aclk);
        #1;
        axi_reset = 1'b0;
        m_tready  = 1'b1;
        @(negedge axi_aclk);
        checkOutput("flush_tvalid", 256'(m_tvalid), 256'(0));
        checkOutput("flush_s_tready0", 256'(s_tready[0]), 256'(1));
        @(posedge axi_aclk);
        #1;
        pushExp(0, mkBase(0, 10), 3);
        pushExp(4, mkBase(4, 10), 2);
        fork
            applyStimulus(4, mkBase(4, 10), 2);
            applyStimulus(0, mkBase(0, 10), 3);
        join
        waitDrain();

        checkOutput("sb_empty", 256'(exp_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
